// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//
// Registered output stage for a small ALU. Each accepted ALU result is
// captured together with its NZCV flags into a two-entry skid buffer. The
// buffer has a "main" entry that drives the outputs and a "skid" entry that
// absorbs one extra word when the downstream stalls. Because of the skid
// entry, in_ready can be a plain register. The stage also counts accepted
// operations and can keep an optional sticky overflow flag.
//
// Optional feature macro: ALU_STICKY_OVF_EN
//   defined   : sticky_v is set on an accepted word whose V flag is 1 and is
//               cleared by clr_sticky. When both happen on the same edge, the
//               set wins.
//   undefined : sticky_v is tied to 0, clr_sticky is ignored, and there is no
//               sticky register.
//
// Parameters
//   WIDTH      ALU result width
//   CNT_W      accepted-operation counter width
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream result present
//   in_ready   stage can accept (registered)
//   in_y       ALU result
//   in_c       ALU carry-out
//   in_v       ALU signed overflow
//   in_op      00 ADD, 01 SUB, 10 AND, 11 OR
//   out_valid  registered result available
//   out_ready  downstream accepts
//   out_y      registered result
//   out_n      N flag of out_y
//   out_z      Z flag of out_y
//   out_c      C flag of out_y
//   out_v      V flag of out_y
//   sticky_v   overflow seen since the last clear
//   clr_sticky clear sticky_v
//   op_count   number of accepted inputs (wraps)
// -----------------------------------------------------------------------------
module alu_result_stage #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_c,
  input  logic             in_v,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_n,
  output logic             out_z,
  output logic             out_c,
  output logic             out_v,
  output logic             sticky_v,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
);

  // A captured word is stored as {y, n, z, c, v}.
  localparam int WW = WIDTH + 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            in_xfer, out_xfer;
  logic            load_main, load_skid, pop_skid;
  logic [WW-1:0]   cap_word_p0;
  logic [WW-1:0]   skid_word_p1;

  // The flags are computed when the word is captured. Logic operations
  // (op[1] = 1) do not produce a carry or an overflow, so C and V are forced
  // to 0 for them.
  function automatic logic [WW-1:0] capture_flags(
    input logic [WIDTH-1:0] y,
    input logic             c,
    input logic             v,
    input logic             logic_op
  );
    logic n, z, cf, vf;
    n  = y[WIDTH-1];
    z  = (y == '0);
    cf = logic_op ? 1'b0 : c;
    vf = logic_op ? 1'b0 : v;
    return {y, n, z, cf, vf};
  endfunction

  // Only bit 1 of in_op affects the flags.
  logic unused_op0;
  assign unused_op0 = in_op[0];

  assign in_xfer     = in_valid & in_ready;
  assign out_xfer    = out_valid & out_ready;
  assign cap_word_p0 = capture_flags(in_y, in_c, in_v, in_op[1]);

  // Next-state logic and buffer steering. In TWO, in_ready is 0, so only an
  // output transfer can occur in that state.
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        case ({in_xfer, out_xfer})
          2'b10: begin
            state_nxt = TWO;
            load_skid = 1'b1;
          end
          2'b01: state_nxt = EMPTY;
          2'b11: load_main = 1'b1;
          default: ;
        endcase
      end
      TWO: begin
        if (out_xfer) begin
          state_nxt = ONE;
          pop_skid  = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // ---- stage p1: main entry (outputs), control and counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      {out_y, out_n, out_z, out_c, out_v} <= '0;
      op_count  <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt != EMPTY);
      if (load_main)
        {out_y, out_n, out_z, out_c, out_v} <= cap_word_p0;
      else if (pop_skid)
        {out_y, out_n, out_z, out_c, out_v} <= skid_word_p1;
      if (in_xfer)
        op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // ---- stage p1: skid entry (data only, no reset needed) ----
  always_ff @(posedge clk) begin
    if (load_skid)
      skid_word_p1 <= cap_word_p0;
  end

`ifdef ALU_STICKY_OVF_EN
  // If a set and a clear happen on the same edge, the set wins.
  always_ff @(posedge clk) begin
    if (rst)
      sticky_v <= 1'b0;
    else if (in_xfer && cap_word_p0[0])
      sticky_v <= 1'b1;
    else if (clr_sticky)
      sticky_v <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = clr_sticky;
  assign sticky_v   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_result_stage
//
// Self-checking bench for alu_result_stage. A queue-based reference model
// keeps the expected buffered words, the operation count and the sticky
// flag. The bench runs directed scenarios and then randomized traffic.
// Inputs are driven after the falling edge. Outputs are compared on the
// next falling edge.
// -----------------------------------------------------------------------------
module tb_alu_result_stage;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_y;
  logic             in_c;
  logic             in_v;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_n, out_z, out_c, out_v;
  logic             sticky_v;
  logic             clr_sticky;
  logic [CNT_W-1:0] op_count;

  alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_y       (in_y),
    .in_c       (in_c),
    .in_v       (in_v),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_n      (out_n),
    .out_z      (out_z),
    .out_c      (out_c),
    .out_v      (out_v),
    .sticky_v   (sticky_v),
    .clr_sticky (clr_sticky),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state. Each expected word is stored as {y, n, z, c, v}.
  logic [WIDTH+3:0] m_q[$];
  logic [CNT_W-1:0] m_cnt;
  logic             m_sticky;

`ifdef ALU_STICKY_OVF_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH+3:0] ref_word(input logic [WIDTH-1:0] y, input logic c,
                                                input logic v, input logic [1:0] op);
    logic is_arith;
    is_arith = (op == 2'b00) || (op == 2'b01);
    return {y, y[WIDTH-1], (y == 0), is_arith & c, is_arith & v};
  endfunction

  task automatic compare_all();
    check("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
    check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0)
      check("out_word", 32'({out_y, out_n, out_z, out_c, out_v}), 32'(m_q[0]));
    check("op_count", 32'(op_count), 32'(m_cnt));
    check("sticky_v", 32'(sticky_v), 32'(m_sticky));
  endtask

  // Drive one cycle of inputs, predict the edge with the model, then compare.
  task automatic step(input logic iv, input logic [WIDTH-1:0] y, input logic c,
                      input logic v, input logic [1:0] op, input logic ordy,
                      input logic clr, input logic r);
    logic in_x, out_x;
    logic [WIDTH+3:0] w;
    rst = r; in_valid = iv; in_y = y; in_c = c; in_v = v; in_op = op;
    out_ready = ordy; clr_sticky = clr;
    in_x  = iv && (m_q.size() < 2);
    out_x = ordy && (m_q.size() > 0);
    w     = ref_word(y, c, v, op);
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_cnt    = '0;
      m_sticky = 1'b0;
    end else begin
      if (out_x) void'(m_q.pop_front());
      if (in_x) begin
        m_q.push_back(w);
        m_cnt = m_cnt + 1'b1;
      end
      if (in_x && w[0])               m_sticky = STICKY_EN;
      else if (clr)                   m_sticky = 1'b0;
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, 1'b0, 1'b0, 2'b00, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    m_cnt = '0; m_sticky = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_y = '0; in_c = 1'b0; in_v = 1'b0;
    in_op = 2'b00; out_ready = 1'b0; clr_sticky = 1'b0;
    @(negedge clk);

    // Reset state
    step(1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    check("rst_out_word", 32'({out_y, out_n, out_z, out_c, out_v}), 32'h0);
    idle(1'b1);
    check("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Basic capture: SUB, y=3, c=1, v=0
    step(1'b1, 4'h3, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
    check("basic_valid", 32'(out_valid), 32'h1);
    check("basic_y", 32'(out_y), 32'h3);
    check("basic_nzcv", 32'({out_n, out_z, out_c, out_v}), 32'b0010);
    check("basic_cnt", 32'(op_count), 32'h1);
    idle(1'b1);

    // Zero and negative flags
    step(1'b1, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    check("zero_zn", 32'({out_z, out_n}), 32'b10);
    step(1'b1, 4'h9, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    check("neg_zn", 32'({out_z, out_n}), 32'b01);
    idle(1'b1);

    // Backpressure: A and B are accepted, C is held off until there is space
    step(1'b1, 4'hA, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hB, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    check("bp_full_ready", 32'(in_ready), 32'h0);
    step(1'b1, 4'hC, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    check("bp_hold_y", 32'(out_y), 32'hA);
    step(1'b1, 4'hC, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
    check("bp_second_y", 32'(out_y), 32'hB);
    step(1'b1, 4'hC, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
    check("bp_third_y", 32'(out_y), 32'hC);
    idle(1'b1);
    check("bp_drained", 32'(out_valid), 32'h0);

    // Logic ops mask C and V. A SUB with V=1 and a clear on the same edge
    // leaves sticky_v set when the feature is enabled.
    step(1'b1, 4'h5, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    check("and_cv", 32'({out_c, out_v}), 32'b00);
    check("and_sticky", 32'(sticky_v), 32'h0);
    step(1'b1, 4'h7, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    check("sub_sticky", 32'(sticky_v), 32'(STICKY_EN));
    step(1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    check("sticky_clear", 32'(sticky_v), 32'h0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 63) == 0));
    end

    // Counter wrap
    step(1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++)
      step(1'b1, 4'($urandom), 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
    check("cnt_wrap", 32'(op_count), 32'h0);

    // Reset while the buffer is full and an input is offered
    idle(1'b1);
    step(1'b1, 4'h6, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hE, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    check("two_ready", 32'(in_ready), 32'h0);
    step(1'b1, 4'hF, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
    check("rst_mid_outs", 32'({out_valid, out_y, out_n, out_z, out_c, out_v, sticky_v}), 32'h0);
    check("rst_mid_ready", 32'(in_ready), 32'h1);
    check("rst_mid_cnt", 32'(op_count), 32'h0);
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the ALU result width.
REQ-002 The block SHALL have parameter CNT_W, default 8, setting the accepted-operation counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream ALU result present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: stage can accept; driven from a register.
REQ-007 The block SHALL have port in_y, input, WIDTH bits: ALU result.
REQ-008 The block SHALL have ports in_c and in_v, input, 1 bit each: ALU carry-out and signed overflow.
REQ-009 The block SHALL have port in_op, input, 2 bits: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-010 The block SHALL have port out_valid, output, 1 bit: registered result available.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-012 The block SHALL have port out_y, output, WIDTH bits: registered result.
REQ-013 The block SHALL have ports out_n, out_z, out_c and out_v, output, 1 bit each: NZCV flags of out_y.
REQ-014 The block SHALL have port sticky_v, output, 1 bit: overflow seen since last clear.
REQ-015 The block SHALL have port clr_sticky, input, 1 bit: clear sticky_v.
REQ-016 The block SHALL have port op_count, output, CNT_W bits: accepted-input count.

Function
REQ-017 An input transfer SHALL occur on an edge where in_valid and in_ready are both 1; an output transfer SHALL occur on an edge where out_valid and out_ready are both 1.
REQ-018 Storage SHALL be a 2-entry skid buffer (main and skid) controlled by an FSM with states EMPTY, ONE and TWO.
REQ-019 FSM transitions SHALL be: EMPTY->ONE on input; ONE->TWO on input without output; ONE->EMPTY on output without input; ONE stays ONE on simultaneous input and output; TWO->ONE on output.
REQ-020 In state TWO, in_ready SHALL be 0; in EMPTY and ONE it SHALL be 1.
REQ-021 A word accepted in EMPTY SHALL appear on out_* with out_valid=1 in the cycle after the accepting edge (1-cycle latency).
REQ-022 Output order SHALL be FIFO; on an output transfer from TWO, the skid entry SHALL move to the outputs on that same edge.
REQ-023 Flags SHALL be computed at capture: N=in_y[WIDTH-1]; Z=1 iff in_y==0; C=in_c and V=in_v when in_op[1]=0; C=V=0 when in_op[1]=1.
REQ-024 out_* SHALL hold their values while out_valid=1 and out_ready=0.
REQ-025 op_count SHALL increment by 1 per input transfer and wrap from 2^CNT_W-1 to 0.
REQ-026 sticky_v SHALL set on an input transfer whose computed V=1; otherwise clr_sticky=1 SHALL clear it; when set and clear coincide, set SHALL win.
REQ-027 in_y, in_c, in_v and in_op SHALL be ignored when no input transfer occurs.

Reset
REQ-028 When rst=1 at an edge, the FSM SHALL go to EMPTY, in_ready SHALL become 1, and out_valid, out_y, out_n, out_z, out_c, out_v, sticky_v and op_count SHALL become 0.
REQ-029 Reset SHALL override simultaneous transfers, so words in flight are discarded and not counted.
REQ-030 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-031 With macro ALU_STICKY_OVF_EN defined, sticky_v and clr_sticky SHALL behave per REQ-026.
REQ-032 Without ALU_STICKY_OVF_EN, sticky_v SHALL be constant 0, clr_sticky SHALL be ignored, and no sticky register SHALL be synthesized.

Verification
REQ-033 Basic capture: out_ready=1, single input in_y=4'h3, in_c=1, in_v=0, in_op=01 -> next cycle out_valid=1, out_y=3, NZCV=0010, op_count=1.
REQ-034 Zero and negative flags: inputs in_y=4'h0 then in_y=4'h9, both with in_op=00, c=0, v=0 -> outputs Z=1, N=0, then Z=0, N=1.
REQ-035 Backpressure: out_ready=0 with 3 consecutive valid inputs A, B, C -> A and B accepted, in_ready=0 after the second edge, C held; with out_ready=1 -> outputs A, B, C in order, with no loss or duplication.
REQ-036 Logic-op masking and sticky: in_op=10 with in_c=1, in_v=1 -> out_c=0, out_v=0, sticky_v unchanged; in_op=01 with v=1 and clr_sticky=1 on the same edge -> sticky_v=1 (macro defined) or 0 (undefined).
REQ-037 Counter wrap: 256 input transfers with CNT_W=8 -> op_count=0.
REQ-038 Reset mid-operation: in state TWO, assert rst during an input transfer -> all outputs 0, in_ready=1, op_count=0.
